// File: rtl/mips_mc_controller_if.sv
// Control bus between the multi-cycle MIPS controller and its datapath.
// The controller owns the master modport; the datapath (or a bench) uses slave.
interface mips_mc_controller_if;
    // Datapath status towards the controller
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    // Datapath control from the controller
    logic       PCEn;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       branch;
    logic       PCSrc;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;

    // Status and debug
    logic       illegal_op;
    logic       mem_timeout;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output PCEn, IorD, MemWrite, IRWrite, PCWrite, branch, PCSrc,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUControl,
               illegal_op, mem_timeout, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  PCEn, IorD, MemWrite, IRWrite, PCWrite, branch, PCSrc,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUControl,
               illegal_op, mem_timeout, state
    );
endinterface

// File: rtl/mips_mc_controller.sv
// Moore-style multi-cycle control FSM for the 64-bit MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback, waits on a slow unified
// memory through mem_ready and flags a stuck memory with a sticky timeout.
// CNT_W must be wide enough that TIMEOUT fits (2**CNT_W > TIMEOUT).
module mips_mc_controller #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_mc_controller_if.master  bus
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXEC   = 4'd6;
    localparam logic [3:0] ALUWB  = 4'd7;
    localparam logic [3:0] BRANCH = 4'd8;
    localparam logic [3:0] ADDIEX = 4'd9;
    localparam logic [3:0] ADDIWB = 4'd10;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT);

    // R-type funct decode: {legal, ALUControl}; unknown functs fall back to add
    function automatic logic [3:0] funct_dec(input logic [5:0] f);
        logic [3:0] r;
        case (f)
            6'b100000: r = {1'b1, ALU_ADD};
            6'b100010: r = {1'b1, ALU_SUB};
            6'b100100: r = {1'b1, ALU_AND};
            6'b100101: r = {1'b1, ALU_OR};
            6'b101010: r = {1'b1, ALU_SLT};
            default:   r = {1'b0, ALU_ADD};
        endcase
        return r;
    endfunction

    logic [3:0]       state_q;
    logic [3:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             mem_timeout_q;
    logic             waiting;
    logic             fn_legal;
    logic [2:0]       fn_alu;

    logic             pcwrite_c;
    logic             irwrite_c;
    logic             memwrite_c;
    logic             regwrite_c;
    logic             branch_c;
    logic             illegal_c;
    logic             iord_c;
    logic             pcsrc_c;
    logic             memtoreg_c;
    logic             regdst_c;
    logic             alusrca_c;
    logic [1:0]       alusrcb_c;
    logic [2:0]       aluctl_c;

    assign {fn_legal, fn_alu} = funct_dec(bus.funct);

    // The FSM only leaves a wait state on mem_ready=1, so "not waiting" also
    // covers the clear-on-state-change rule for the wait counter.
    assign waiting = ((state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR))
                     && !bus.mem_ready;
    assign cnt_inc = (cnt_q == TMAX) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state and per-state control decode; unlisted outputs default to 0
    always_comb begin
        state_d    = state_q;
        pcwrite_c  = 1'b0;
        irwrite_c  = 1'b0;
        memwrite_c = 1'b0;
        regwrite_c = 1'b0;
        branch_c   = 1'b0;
        illegal_c  = 1'b0;
        iord_c     = 1'b0;
        pcsrc_c    = 1'b0;
        memtoreg_c = 1'b0;
        regdst_c   = 1'b0;
        alusrca_c  = 1'b0;
        alusrcb_c  = SRCB_B;
        aluctl_c   = ALU_AND;
        case (state_q)
            FETCH: begin
                alusrcb_c = SRCB_FOUR;
                aluctl_c  = ALU_ADD;
                if (bus.mem_ready) begin
                    irwrite_c = 1'b1;
                    pcwrite_c = 1'b1;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                // Branch target pc+4+(imm<<2) lands in ALUOut here
                alusrcb_c = SRCB_IMM4;
                aluctl_c  = ALU_ADD;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca_c = 1'b1;
                alusrcb_c = SRCB_IMM;
                aluctl_c  = ALU_ADD;
                state_d   = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                // ALU settings held so ALUOut (the address) stays stable
                iord_c    = 1'b1;
                alusrca_c = 1'b1;
                alusrcb_c = SRCB_IMM;
                aluctl_c  = ALU_ADD;
                if (bus.mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                memtoreg_c = 1'b1;
                regwrite_c = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                iord_c     = 1'b1;
                memwrite_c = 1'b1;
                alusrca_c  = 1'b1;
                alusrcb_c  = SRCB_IMM;
                aluctl_c   = ALU_ADD;
                if (bus.mem_ready) state_d = FETCH;
            end
            EXEC: begin
                alusrca_c = 1'b1;
                alusrcb_c = SRCB_B;
                aluctl_c  = fn_alu;
                if (fn_legal) begin
                    state_d = ALUWB;
                end else begin
                    illegal_c = 1'b1;
                    state_d   = FETCH;
                end
            end
            ALUWB: begin
                regdst_c   = 1'b1;
                regwrite_c = 1'b1;
                aluctl_c   = fn_alu;
                state_d    = FETCH;
            end
            BRANCH: begin
                alusrca_c = 1'b1;
                alusrcb_c = SRCB_B;
                aluctl_c  = ALU_SUB;
                branch_c  = 1'b1;
                pcsrc_c   = 1'b1;
                state_d   = FETCH;
            end
            ADDIEX: begin
                alusrca_c = 1'b1;
                alusrcb_c = SRCB_IMM;
                aluctl_c  = ALU_ADD;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                regwrite_c = 1'b1;
                alusrca_c  = 1'b1;
                alusrcb_c  = SRCB_IMM;
                aluctl_c   = ALU_ADD;
                state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // Memory wait counter with saturating count and sticky timeout flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q         <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            cnt_q <= waiting ? cnt_inc : '0;
            if (waiting && (cnt_inc == TMAX)) mem_timeout_q <= 1'b1;
        end
    end

    // Write strobes are gated by reset so they drop the moment reset asserts
    assign bus.PCEn       = (pcwrite_c | (branch_c & bus.zero)) & reset;
    assign bus.PCWrite    = pcwrite_c  & reset;
    assign bus.IRWrite    = irwrite_c  & reset;
    assign bus.MemWrite   = memwrite_c & reset;
    assign bus.RegWrite   = regwrite_c & reset;
    assign bus.branch     = branch_c   & reset;
    assign bus.illegal_op = illegal_c  & reset;

    assign bus.IorD        = iord_c;
    assign bus.PCSrc       = pcsrc_c;
    assign bus.MemtoReg    = memtoreg_c;
    assign bus.RegDst      = regdst_c;
    assign bus.ALUSrcA     = alusrca_c;
    assign bus.ALUSrcB     = alusrcb_c;
    assign bus.ALUControl  = aluctl_c;
    assign bus.mem_timeout = mem_timeout_q;
    assign bus.state       = state_q;

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
- Moore-style multi-cycle control FSM that sequences the 64-bit MIPS multi-cycle datapath: fetch, decode, execute, memory and writeback steps.
- Decodes opcode instr[31:26] and funct instr[5:0] from the instruction register.
- Drives every datapath control input.
- Adds a memory ready handshake with a stall timeout so the datapath can sit on a slow unified memory.

Parameters:
- TIMEOUT, 255: maximum consecutive cycles waiting on mem_ready before mem_timeout is set.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- PCEn  out  1  PC register enable
- IorD  out  1  memory address select: 0 = pc, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register enable
- PCWrite  out  1  unconditional PC write
- branch  out  1  conditional PC write
- PCSrc  out  1  next-PC select: 0 = ALUResult, 1 = ALUOut
- MemtoReg  out  1  writeback select: 0 = ALUOut, 1 = data
- RegDst  out  1  destination select: 0 = rt, 1 = rd
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0 = pc, 1 = A
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = sign-extended immediate, 11 = immediate shifted left 2
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal_op  out  1  one-cycle pulse on an unsupported opcode or funct
- mem_timeout  out  1  sticky error flag
- state  out  4  current state, for debug

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10.
- Reset (reset=0, async):
  - state goes to FETCH; wait counter clears; mem_timeout clears.
  - While reset=0, PCEn, IRWrite, PCWrite, MemWrite, RegWrite, branch and illegal_op are all forced to 0.
- Output combining: PCEn = PCWrite | (branch & zero). Every output not listed for a state is 0.
- FETCH:
  - Outputs: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=0.
  - IRWrite and PCWrite are asserted only in the cycle where mem_ready=1; the state then advances to DECODE. Otherwise the FSM stays in FETCH.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUControl=010 (branch target is placed in ALUOut).
  - Next state by opcode:
    - 100011 lw and 101011 sw go to MEMADR.
    - 000000 R-type goes to EXEC.
    - 000100 beq goes to BRANCH.
    - 001000 addi goes to ADDIEX.
    - Any other opcode goes to FETCH with illegal_op=1 for that cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=010. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD:
  - Outputs: IorD=1, with ALUSrcA=1, ALUSrcB=10, ALUControl=010 held so ALUOut stays stable.
  - Stays until mem_ready=1, then goes to MEMWB. The data register captures readdata on that edge.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next state is FETCH.
- MEMWR:
  - Outputs: IorD=1, MemWrite=1, with the same ALU holds as MEMRD.
  - MemWrite stays high every cycle until mem_ready=1, then the state goes to FETCH.
- EXEC:
  - Outputs: ALUSrcA=1, ALUSrcB=00.
  - ALUControl from funct: 100000 gives 010, 100010 gives 110, 100100 gives 000, 100101 gives 001, 101010 gives 111.
  - Any other funct gives ALUControl=010 and illegal_op=1, and the next state is FETCH with no writeback. A legal funct goes to ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, and ALUControl is held from funct. Next state is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, branch=1, PCSrc=1. Next state is FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=010. Next state is ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, with the ADDIEX ALU settings held. Next state is FETCH.
- Wait counter:
  - Increments each cycle the FSM is in FETCH, MEMRD or MEMWR with mem_ready=0.
  - Clears on mem_ready=1 and on any state change.
  - Saturates at TIMEOUT. On reaching TIMEOUT, mem_timeout is set.
  - mem_timeout is sticky until reset; the FSM keeps waiting regardless.
- Latencies with zero wait: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, illegal 2.

Test Plan:
- Reset low mid-MEMWR with MemWrite=1 -> MemWrite drops immediately (async), state=0. After reset rises, the first cycle is FETCH.
- lw, mem_ready tied 1 -> state sequence 0,1,2,3,4,0. IRWrite/PCWrite high only in cycle 0; RegWrite=1 with MemtoReg=1 in state 4.
- sw with mem_ready low 3 cycles in MEMWR -> MemWrite=1 for exactly 4 cycles, IorD=1 throughout. PCEn=0 until the next FETCH handshake.
- R-type funct=101010 -> ALUControl=111 in EXEC and ALUWB, RegDst=1, RegWrite=1 only in ALUWB. Funct=000111 -> illegal_op pulses once, no RegWrite.
- beq with zero=1 -> PCEn=1 in BRANCH. With zero=0 -> PCEn=0. ALUControl=110, PCSrc=1 in both cases.
- FETCH with mem_ready=0 for 260 cycles, TIMEOUT=255 -> mem_timeout rises when the counter reaches 255 and stays set. The FSM remains in FETCH; a later mem_ready=1 advances to DECODE.
